// File: rtl/seg_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver_pkg
// Description : Shared scan-state encoding, anode constants and digit helpers
//               for the multiplexed 7-segment source driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_driver_pkg;

    localparam int          IDX_W     = 2;
    localparam logic [3:0]  ANODE_OFF = 4'b1111;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Active-low one-cold anode pattern for a digit index
    function automatic logic [3:0] anode_on(input logic [IDX_W-1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    function automatic logic [3:0] nibble_at(input logic [15:0] word, input logic [IDX_W-1:0] idx);
        return word[{idx, 2'b00} +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_timer
// Description : Phase tick counter with synchronous clear and terminal-count
//               compare against a limit chosen by the scan FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = i_clr ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tc = (cnt_q == i_limit);

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Time-multiplexes a double-buffered 4-digit hex word onto one
//               hex-to-7-segment decoder with dead-time between digits.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SCAN_TICKS = 50000,
    parameter int DEAD_TICKS = 200,
    parameter int CNT_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data,
    input  logic [3:0]  points,
    input  logic [3:0]  blank,
    input  logic        load,
    output logic [3:0]  hex,
    output logic        le,
    output logic        point,
    output logic [3:0]  an,
    output logic        frame_done
);

    // Display word layout: {blank[3:0], points[3:0], data[15:0]}
    logic [23:0]      in_word;
    logic [23:0]      shadow_q, shadow_d;
    logic [23:0]      active_q, active_d;
    logic             pending_q, pending_d;
    scan_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [3:0]       hex_q, hex_d;
    logic             le_q, le_d;
    logic             point_q, point_d;
    logic             frame_done_q, frame_done_d;
    logic [CNT_W-1:0] cnt_limit;
    logic             tc;

    assign in_word = {blank, points, data};

    seg_scan_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (tc),
        .i_limit (cnt_limit),
        .o_tc    (tc)
    );

    always_comb begin
        cnt_limit    = (state_q == ST_BLANK) ? CNT_W'(DEAD_TICKS - 1) : CNT_W'(SCAN_TICKS - 1);
        state_d      = state_q;
        idx_d        = idx_q;
        active_d     = active_q;
        shadow_d     = load ? in_word : shadow_q;
        pending_d    = pending_q | load;
        frame_done_d = 1'b0;

        if (tc) begin
            if (state_q == ST_BLANK) begin
                state_d = ST_SHOW;
            end else begin
                state_d = ST_BLANK;
                if (idx_q == IDX_W'(DIGITS - 1)) begin
                    idx_d        = '0;
                    frame_done_d = 1'b1;
                    // A load landing on the swap cycle bypasses the shadow so it is never a frame late
                    if (load) begin
                        active_d  = in_word;
                        pending_d = 1'b0;
                    end else if (pending_q) begin
                        active_d  = shadow_q;
                        pending_d = 1'b0;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end

        // Outputs are built from next-state values so the registers track the FSM exactly
        hex_d   = nibble_at(active_d[15:0], idx_d);
        point_d = active_d[16 + int'(idx_d)];
        an_d    = ANODE_OFF;
        le_d    = 1'b1;
        if (state_d == ST_SHOW) begin
            an_d = anode_on(idx_d);
            le_d = active_d[20 + int'(idx_d)];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            idx_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            an_q         <= ANODE_OFF;
            hex_q        <= 4'h0;
            le_q         <= 1'b1;
            point_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            hex_q        <= hex_d;
            le_q         <= le_d;
            point_q      <= point_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign hex        = hex_q;
    assign le         = le_q;
    assign point      = point_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire
